// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux share arbiter.
// Holds the FSM encoding, the select-width helper and legal parameter ranges.
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int NUM_REQ_MIN  = 2;
    localparam int NUM_REQ_MAX  = 8;
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 255;
    localparam int TIMEOUT_MIN  = 2;
    localparam int TIMEOUT_MAX  = 255;

    // Never returns less than 1 so a select port always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i, modulo N.
// Zero latency, no state; callers hold rr_ptr_i stable while they sample idx_o.
module rr_pick #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] rr_ptr_i,
    output logic             any_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W:0] sum;

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_i} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(N)) sum = sum - (SEL_W + 1)'(N);
            if (req_i[sum[SEL_W-1:0]]) begin
                any_o = 1'b1;
                idx_o = sum[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared N:1 mux; grant 1 cycle after request, data path combinational.
// Bursts end on last or MAX_HOLD beats; optional idle-stall release via MUX_ARB_TIMEOUT_EN.
module mux_share_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 2,
    parameter  int DATA_W   = 8,
    parameter  int MAX_HOLD = 4,
    parameter  int TIMEOUT  = 16,
    localparam int SEL_W    = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          sel,
    output logic                      busy,
    output logic                      timeout_pulse
);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
        MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX ||
        TIMEOUT < TIMEOUT_MIN || TIMEOUT > TIMEOUT_MAX) begin : g_bad_param
        $error("mux_share_arbiter: parameter out of legal range");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             granted, sel_vld, beat_acc, release_now, timeout_fire;

    rr_pick #(
        .N     (NUM_REQ),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx)
    );

    assign granted   = (state_q == GRANT);
    assign sel_vld   = req_valid[sel_q];
    assign out_valid = granted & sel_vld;
    assign out_last  = granted & req_last[sel_q];
    assign out_data  = granted ? req_data[int'(sel_q)*DATA_W +: DATA_W] : '0;
    assign req_ready = (granted && out_ready) ? (NUM_REQ'(1) << sel_q) : '0;
    assign beat_acc  = out_valid & out_ready;
    assign sel       = sel_q;
    assign busy      = granted;

    // Last and hold-limit on the same beat collapse into one release.
    assign release_now = (beat_acc && (req_last[sel_q] || hold_cnt_q == 8'(MAX_HOLD - 1)))
                         || timeout_fire;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] stall_q, stall_d;

    // Only an absent grantee counts; a downstream stall keeps valid high and clears it.
    always_comb begin
        stall_d = '0;
        if (granted && !sel_vld) stall_d = stall_q + 8'd1;
    end

    assign timeout_fire = granted && !sel_vld && (stall_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`else
    assign timeout_fire = 1'b0;
`endif

    assign timeout_pulse = timeout_fire;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d      = pick_idx;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (beat_acc) hold_cnt_d = hold_cnt_q + 8'd1;
                if (release_now) begin
                    state_d  = IDLE;
                    rr_ptr_d = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Shares one N:1 select mux between NUM_REQ requesters, round-robin, with valid/ready handshakes.
- Owns the mux `sel` register and gates the mux output toward one downstream consumer.
- Grants are held for a burst, ending on `last` or after MAX_HOLD beats, so packets are not interleaved.
- Sits between the requester FIFOs and the shared mux/output path.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- DATA_W, 8, data width per requester.
- MAX_HOLD, 4, maximum beats per grant; legal range 1..255.
- TIMEOUT, 16, idle-stall cycles before a forced release; used only with MUX_ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester end-of-burst flag, qualified by valid.
- req_data  in  NUM_REQ*DATA_W  packed data; requester i occupies [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept.
- out_valid  out  1  downstream valid.
- out_last  out  1  downstream last.
- out_data  out  DATA_W  muxed data.
- out_ready  in  1  downstream accept.
- sel  out  SEL_W  current mux select; SEL_W = clog2(NUM_REQ).
- busy  out  1  a grant is active.
- timeout_pulse  out  1  forced-release strobe; tied 0 when the feature is absent.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, sel=0, rr_ptr=0, hold_cnt=0.
  - busy=0, req_ready=0, out_valid=0, timeout_pulse=0.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is high: pick the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Register the pick into sel, set hold_cnt=0, go to GRANT.
  - Grant latency is 1 cycle.
  - With no valid requests, stay in IDLE; sel holds its last value.
- GRANT:
  - out_valid = req_valid[sel]; out_data = req_data[sel]; out_last = req_last[sel]. This path is combinational, zero latency.
  - req_ready[i] = out_ready && (i==sel); all other bits are 0.
  - Beat accepted = out_valid && out_ready; each beat increments hold_cnt.
- Release:
  - Triggers: an accepted beat with last=1, or an accepted beat with hold_cnt==MAX_HOLD-1.
  - On release: go to IDLE, rr_ptr = sel+1 (wraps to 0 after NUM_REQ-1).
  - One idle bubble cycle always follows a release; there is no same-cycle re-grant.
- Hold-limit and last on the same beat count as a single release; no double advance.
- A grantee dropping valid mid-burst keeps the grant; data stays stalled and no beat is counted.
- Requests arriving while in GRANT are held off (req_ready=0) until the next arbitration.
- In IDLE, out_valid=0 and req_ready=0 regardless of inputs.
- busy=1 exactly while in GRANT.
- Reset mid-burst: immediate return to reset values; the partial burst is abandoned with no completion signalled.
- Fairness: a continuously requesting requester waits at most (NUM_REQ-1) bursts plus bubbles.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - Stall counter counts GRANT cycles with req_valid[sel]=0; it clears on any valid.
  - At TIMEOUT it forces a release exactly as a last-beat release would: rr_ptr advances, state goes to IDLE.
  - timeout_pulse is high for 1 cycle on the forced release.
  - A downstream stall (valid=1, ready=0) never counts.
- Undefined:
  - No stall counter.
  - timeout_pulse is tied 0.
  - The grant is held indefinitely until last or MAX_HOLD.

Decomposition:
- Package mux_arb_pkg holds:
  - state encoding constants (IDLE=1'b0, GRANT=1'b1);
  - the clog2 function;
  - the MAX_HOLD/TIMEOUT legal-range constants.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr. Outputs: any, grant index.
  - Instantiated once in the top.
- Everything else stays in the top.

Test Plan:
- Single requester bursts:
  - Stimulus: only req0 valid, 3 beats AA,BB,CC, last on CC, out_ready=1.
  - Response: grant 1 cycle after valid; out_data AA,BB,CC on consecutive cycles; busy drops after CC; sel=0.
- Round-robin alternation:
  - Stimulus: req0 and req1 continuously valid, 1-beat bursts with last=1.
  - Response: sel sequence 0,1,0,1 with one bubble between grants; each requester gets 50% of beats.
- Hold limit:
  - Stimulus: MAX_HOLD=4, req1 sends 6 beats with no last, req0 also valid.
  - Response: 4 beats from req1, release, req0 granted, then req1 resumes with beats 5-6.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 during a 2-beat burst.
  - Response: req_ready mirrors out_ready; hold_cnt advances only on accepted beats; data stable while stalled.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 after beat 2 of 4 from req1.
  - Response: outputs zero asynchronously; after release with req0 valid, sel=0 is granted first because rr_ptr=0.
- Timeout (macro defined, TIMEOUT=16):
  - Stimulus: grantee drops valid for 16 cycles.
  - Response: timeout_pulse for 1 cycle, then the other requester is granted.
  - Macro undefined: the grant persists and timeout_pulse stays 0.
